// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction fetch
//   port (I_*) and the data access port (D_*). Only one transaction can be
//   outstanding at a time. Data requests normally win. A starvation counter
//   forces a fetch grant after STARVE_MAX data grants have gone by while a
//   fetch was waiting.
//
//   Parameters
//     MEM_LAT     cycles from the M_EN cycle to valid M_RDATA (>= 1)
//     STARVE_MAX  data grants tolerated while I_REQ waits (>= 1)
//
//   Ports
//     CLK, RSTN                     clock, synchronous active-low reset
//     I_REQ/I_ADDR/I_KILL           fetch request, address, response discard
//     I_GNT/I_RVALID/I_RDATA        fetch accept pulse, response pulse, data
//     D_REQ/D_WE/D_BE/D_ADDR/D_WDATA  data request and its attributes
//     D_GNT/D_RVALID/D_RDATA        data accept pulse, response pulse, data
//     M_EN/M_WE/M_BE/M_ADDR/M_WDATA memory command, driven in the grant cycle
//     M_RDATA                       memory read data, MEM_LAT cycles later
//     BUSY                          a transaction is outstanding
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    input  logic        I_KILL,
    output logic        I_GNT,
    output logic        I_RVALID,
    output logic [31:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [3:0]  D_BE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,
    output logic        M_EN,
    output logic        M_WE,
    output logic [3:0]  M_BE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA,
    output logic        BUSY
);

    localparam int WCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] WAIT_INIT  = WCW'(MEM_LAT);
    localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
    localparam logic [SCW-1:0] STARVE_ONE = SCW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [WCW-1:0] wait_cnt_r;
    logic [SCW-1:0] starve_cnt_r;
    logic [SCW-1:0] starve_cnt_s;
    logic           owner_d_r;
    logic           is_write_r;
    logic           kill_r;
    logic           kill_s;
    logic           i_win_s;
    logic           d_win_s;
    logic           done_s;
    logic           fetch_live_s;
    logic           i_rvalid_r;
    logic           d_rvalid_r;
    logic [31:0]    i_rdata_r;
    logic [31:0]    d_rdata_r;

    // The last WAIT cycle: the counter steps to zero on the coming edge.
    assign done_s       = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_ONE);
    // A fetch still waiting for its data, so I_KILL applies to it.
    assign fetch_live_s = (state_r == ST_WAIT) && !owner_d_r;

    // Arbitration: only in IDLE and never while reset is held, so a request
    // seen during reset is granted in the first cycle after release.
    always_comb begin
        d_win_s = 1'b0;
        i_win_s = 1'b0;
        if (RSTN && (state_r == ST_IDLE)) begin
            if (D_REQ && !(I_REQ && (starve_cnt_r == STARVE_TOP))) begin
                d_win_s = 1'b1;
            end else if (I_REQ) begin
                i_win_s = 1'b1;
            end else begin
                d_win_s = 1'b0;
                i_win_s = 1'b0;
            end
        end else begin
            d_win_s = 1'b0;
            i_win_s = 1'b0;
        end
    end

    // Memory command mux; everything is zero whenever M_EN is low.
    always_comb begin
        M_EN    = 1'b0;
        M_WE    = 1'b0;
        M_BE    = 4'h0;
        M_ADDR  = 32'h0;
        M_WDATA = 32'h0;
        if (d_win_s) begin
            M_EN    = 1'b1;
            M_WE    = D_WE;
            M_BE    = D_BE;
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
        end else if (i_win_s) begin
            M_EN    = 1'b1;
            M_BE    = 4'hF;
            M_ADDR  = I_ADDR;
        end else begin
            M_EN    = 1'b0;
        end
    end

    // Next-state logic for the IDLE/WAIT sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_win_s || i_win_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!I_REQ || i_win_s) begin
            starve_cnt_s = {SCW{1'b0}};
        end else if (d_win_s && (starve_cnt_r != STARVE_TOP)) begin
            starve_cnt_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Kill flag: armed by I_KILL from the fetch grant cycle through the last
    // WAIT cycle, dropped once that fetch has retired.
    always_comb begin
        kill_s = kill_r;
        if (i_win_s) begin
            kill_s = I_KILL;
        end else if (done_s) begin
            kill_s = 1'b0;
        end else if (fetch_live_s) begin
            kill_s = kill_r | I_KILL;
        end else begin
            kill_s = kill_r;
        end
    end

    // Sequencer state, transaction attributes and counters.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {WCW{1'b0}};
            starve_cnt_r <= {SCW{1'b0}};
            owner_d_r    <= 1'b0;
            is_write_r   <= 1'b0;
            kill_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
            kill_r       <= kill_s;
            if (d_win_s || i_win_s) begin
                wait_cnt_r <= WAIT_INIT;
                owner_d_r  <= d_win_s;
                is_write_r <= d_win_s & D_WE;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r - WAIT_ONE;
            end
        end
    end

    // Response registers: data captured on the last WAIT cycle, presented
    // with a one-cycle RVALID in the following IDLE cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_rdata_r  <= 32'h0;
            d_rdata_r  <= 32'h0;
        end else begin
            i_rvalid_r <= done_s && !owner_d_r && !(kill_r | I_KILL);
            d_rvalid_r <= done_s && owner_d_r;
            if (done_s && !owner_d_r && !(kill_r | I_KILL)) begin
                i_rdata_r <= M_RDATA;
            end
            if (done_s && owner_d_r) begin
                d_rdata_r <= is_write_r ? 32'h0 : M_RDATA;
            end
        end
    end

    assign I_GNT    = i_win_s;
    assign D_GNT    = d_win_s;
    assign I_RVALID = i_rvalid_r;
    assign D_RVALID = d_rvalid_r;
    assign I_RDATA  = i_rdata_r;
    assign D_RDATA  = d_rdata_r;
    assign BUSY     = (state_r == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        I_REQ, I_KILL, I_GNT, I_RVALID;
    logic [31:0] I_ADDR, I_RDATA;
    logic        D_REQ, D_WE, D_GNT, D_RVALID;
    logic [3:0]  D_BE;
    logic [31:0] D_ADDR, D_WDATA, D_RDATA;
    logic        M_EN, M_WE, BUSY;
    logic [3:0]  M_BE;
    logic [31:0] M_ADDR, M_WDATA, M_RDATA;

    int checks = 0;
    int errors = 0;

    // Behavioural memory plus a preload path used while the DUT is idle.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:LAT-1];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] model_mem [0:15];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_KILL(I_KILL), .I_GNT(I_GNT),
        .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_EN(M_EN), .M_WE(M_WE), .M_BE(M_BE), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .BUSY(BUSY)
    );

    // Memory: byte-enabled writes, reads appear LAT cycles after the M_EN cycle.
    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (M_EN && M_WE) begin
            for (int b = 0; b < 4; b++) begin
                if (M_BE[b]) mem[M_ADDR[11:2]][8*b +: 8] <= M_WDATA[8*b +: 8];
            end
        end
        rd_pipe[0] <= M_EN ? mem[M_ADDR[11:2]] : 32'h0;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign M_RDATA = rd_pipe[LAT-1];

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = addr[11:2];
        pl_data = data;
        nxt();
        pl_en = 1'b0;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        D_REQ = req; D_WE = we; D_BE = be; D_ADDR = addr; D_WDATA = wdata;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; I_REQ = 1'b1; D_REQ = 1'b1;
        nxt();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({I_GNT, D_GNT, I_RVALID, D_RVALID, M_EN, M_WE, BUSY} !== 7'b0 ||
                I_RDATA !== 32'h0 || D_RDATA !== 32'h0 || M_ADDR !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: gnt=%b%b rv=%b%b men=%b busy=%b ird=%h drd=%h, required all 0",
                         I_GNT, D_GNT, I_RVALID, D_RVALID, M_EN, BUSY, I_RDATA, D_RDATA);
            end
            nxt();
        end
        RSTN = 1'b1; I_REQ = 1'b0; D_REQ = 1'b0;
    endtask

    task automatic test_single_fetch();
        preload(32'h100, 32'h00500093);
        I_REQ = 1'b1; I_ADDR = 32'h100;
        @(negedge CLK);
        checks++;
        if ({I_GNT, D_GNT, M_EN, M_WE, M_BE} !== 8'b1010_1111 || M_ADDR !== 32'h100 || M_WDATA !== 32'h0) begin
            errors++;
            $display("FAIL fetch_grant: gnt=%b men=%b mwe=%b mbe=%h addr=%h, required 1 1 0 f 00000100",
                     I_GNT, M_EN, M_WE, M_BE, M_ADDR);
        end
        nxt(); I_REQ = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b1 || I_RVALID !== 1'b0 || M_EN !== 1'b0) begin
                errors++;
                $display("FAIL fetch_busy c%0d: busy=%b rvalid=%b men=%b, required 1 0 0", c, BUSY, I_RVALID, M_EN);
            end
            nxt();
        end
        @(negedge CLK);
        checks++;
        if (I_RVALID !== 1'b1 || I_RDATA !== 32'h00500093 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid: rvalid=%b rdata=%h busy=%b, required 1 00500093 0", I_RVALID, I_RDATA, BUSY);
        end
        nxt();
        @(negedge CLK);
        checks++;
        if (I_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid_pulse: rvalid=%b, required 0", I_RVALID);
        end
        nxt();
    endtask

    task automatic test_store_load();
        drive_d(1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF);
        @(negedge CLK);
        checks++;
        if ({D_GNT, I_GNT, M_EN, M_WE, M_BE} !== 8'b1011_1111 || M_ADDR !== 32'h200 || M_WDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_grant: gnt=%b men=%b mwe=%b mbe=%h addr=%h wdata=%h, required 1 1 1 f 200 deadbeef",
                     D_GNT, M_EN, M_WE, M_BE, M_ADDR, M_WDATA);
        end
        nxt(); D_REQ = 1'b0;
        nxt(); nxt();
        drive_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        @(negedge CLK);
        checks++;
        if (D_RVALID !== 1'b1 || D_RDATA !== 32'h0 || D_GNT !== 1'b1) begin
            errors++;
            $display("FAIL store_done: rvalid=%b rdata=%h gnt=%b, required 1 0 1", D_RVALID, D_RDATA, D_GNT);
        end
        nxt(); D_REQ = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        checks++;
        if (D_RVALID !== 1'b1 || D_RDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_back: rvalid=%b rdata=%h, required 1 deadbeef", D_RVALID, D_RDATA);
        end
        nxt();
    endtask

    task automatic test_byte_store();
        preload(32'h300, 32'h11223344);
        drive_d(1'b1, 1'b1, 4'b0010, 32'h300, 32'h0000AB00);
        @(negedge CLK);
        checks++;
        if (D_GNT !== 1'b1 || M_BE !== 4'b0010 || M_WE !== 1'b1) begin
            errors++;
            $display("FAIL byte_store: gnt=%b mbe=%b mwe=%b, required 1 0010 1", D_GNT, M_BE, M_WE);
        end
        nxt(); D_REQ = 1'b0;
        nxt(); nxt();
        drive_d(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        nxt(); D_REQ = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        checks++;
        if (D_RVALID !== 1'b1 || D_RDATA !== 32'h1122AB44) begin
            errors++;
            $display("FAIL byte_load: rvalid=%b rdata=%h, required 1 1122ab44", D_RVALID, D_RDATA);
        end
        nxt();
    endtask

    task automatic test_kill();
        preload(32'h104, 32'hCAFEF00D);
        I_REQ = 1'b1; I_ADDR = 32'h104;
        @(negedge CLK);
        checks++;
        if (I_GNT !== 1'b1) begin
            errors++;
            $display("FAIL kill_grant: gnt=%b, required 1", I_GNT);
        end
        nxt(); I_REQ = 1'b0; I_KILL = 1'b1;
        nxt(); I_KILL = 1'b0;
        nxt();
        drive_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        @(negedge CLK);
        checks++;
        if (I_RVALID !== 1'b0 || I_RDATA !== 32'h00500093 || D_GNT !== 1'b1) begin
            errors++;
            $display("FAIL kill_suppress: irvalid=%b irdata=%h dgnt=%b, required 0 00500093 1", I_RVALID, I_RDATA, D_GNT);
        end
        nxt(); D_REQ = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        checks++;
        if (D_RVALID !== 1'b1 || D_RDATA !== 32'hDEADBEEF || I_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL kill_dnext: drvalid=%b drdata=%h irvalid=%b, required 1 deadbeef 0", D_RVALID, D_RDATA, I_RVALID);
        end
        nxt();
        I_REQ = 1'b1; I_ADDR = 32'h104;
        nxt(); I_REQ = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        checks++;
        if (I_RVALID !== 1'b1 || I_RDATA !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL kill_cleared: rvalid=%b rdata=%h, required 1 cafef00d", I_RVALID, I_RDATA);
        end
        nxt();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        I_REQ = 1'b1; I_ADDR = 32'h100;
        drive_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        for (int k = 0; k < 30; k++) begin
            if (k % 3 != 0) exp_g = 2'b00;
            else if ((k / 3) % 5 == 4) exp_g = 2'b10;
            else exp_g = 2'b01;
            @(negedge CLK);
            checks++;
            if ({I_GNT, D_GNT} !== exp_g) begin
                errors++;
                $display("FAIL contention c%0d: {ignt,dgnt}=%b, required %b", k, {I_GNT, D_GNT}, exp_g);
            end
            nxt();
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        nxt();
    endtask

    task automatic test_reset_mid();
        drive_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        @(negedge CLK);
        checks++;
        if (D_GNT !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: gnt=%b, required 1", D_GNT);
        end
        nxt(); D_REQ = 1'b0; RSTN = 1'b0;
        nxt();
        drive_d(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        @(negedge CLK);
        checks++;
        if ({I_GNT, D_GNT, I_RVALID, D_RVALID, M_EN, BUSY} !== 6'b0 || I_RDATA !== 32'h0 || D_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_zero: gnt=%b%b rv=%b%b men=%b busy=%b ird=%h drd=%h, required all 0",
                     I_GNT, D_GNT, I_RVALID, D_RVALID, M_EN, BUSY, I_RDATA, D_RDATA);
        end
        nxt(); RSTN = 1'b1;
        @(negedge CLK);
        checks++;
        if (D_GNT !== 1'b1 || D_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: gnt=%b rvalid=%b, required 1 0", D_GNT, D_RVALID);
        end
        nxt(); D_REQ = 1'b0;
        for (int c = 4; c <= 5; c++) begin
            @(negedge CLK);
            checks++;
            if (D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_norvalid c%0d: rvalid=%b, required 0", c, D_RVALID);
            end
            nxt();
        end
        @(negedge CLK);
        checks++;
        if (D_RVALID !== 1'b1 || D_RDATA !== 32'h00500093) begin
            errors++;
            $display("FAIL rstmid_after: rvalid=%b rdata=%h, required 1 00500093", D_RVALID, D_RDATA);
        end
        nxt();
    endtask

    // Randomized traffic against a cycle-count model: the port is free again
    // LAT+1 cycles after each grant, and responses are due at that cycle.
    task automatic test_random();
        int free_at = 0, done_at = -1, starve = 0;
        logic own_d = 1'b0, killed = 1'b0, i_hold = 1'b0, d_hold = 1'b0;
        logic [31:0] exp_data = 32'h0, m_ird = 32'h0, m_drd = 32'h0;
        logic idle, e_ig, e_dg, e_iv, e_dv, e_en, e_we;
        logic [3:0] e_be;
        logic [31:0] e_addr, e_wd, w;
        RSTN = 1'b0; I_KILL = 1'b0;
        nxt(); RSTN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            model_mem[i] = w;
            preload(32'h800 + 32'(i * 4), w);
        end
        for (int c = 0; c < 400; c++) begin
            if (!i_hold) begin
                I_REQ = ($urandom_range(0, 2) != 0);
                I_ADDR = 32'h800 + 32'($urandom_range(0, 15) * 4);
            end
            if (!d_hold) begin
                drive_d($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
                        32'h800 + 32'($urandom_range(0, 15) * 4), $urandom);
            end
            I_KILL = ($urandom_range(0, 5) == 0);
            e_iv = (c == done_at) && !own_d && !killed;
            e_dv = (c == done_at) && own_d;
            if (e_iv) m_ird = exp_data;
            if (e_dv) m_drd = exp_data;
            idle = (c >= free_at);
            e_dg = idle && D_REQ && !(I_REQ && starve == SMAX);
            e_ig = idle && I_REQ && !e_dg;
            e_en = e_dg || e_ig;
            e_we = e_dg && D_WE;
            e_be = e_dg ? D_BE : (e_ig ? 4'hF : 4'h0);
            e_addr = e_dg ? D_ADDR : (e_ig ? I_ADDR : 32'h0);
            e_wd = e_dg ? D_WDATA : 32'h0;
            @(negedge CLK);
            checks++;
            if ({I_GNT, D_GNT, M_EN, M_WE, M_BE, BUSY} !== {e_ig, e_dg, e_en, e_we, e_be, !idle}) begin
                errors++;
                $display("FAIL rnd_ctrl c%0d: ig dg en we be busy=%b %b %b %b %h %b, required %b %b %b %b %h %b", c,
                         I_GNT, D_GNT, M_EN, M_WE, M_BE, BUSY, e_ig, e_dg, e_en, e_we, e_be, !idle);
            end
            checks++;
            if (M_ADDR !== e_addr || M_WDATA !== e_wd) begin
                errors++;
                $display("FAIL rnd_mem c%0d: addr=%h wdata=%h, required %h %h", c, M_ADDR, M_WDATA, e_addr, e_wd);
            end
            checks++;
            if ({I_RVALID, D_RVALID} !== {e_iv, e_dv} || I_RDATA !== m_ird || D_RDATA !== m_drd) begin
                errors++;
                $display("FAIL rnd_resp c%0d: rv=%b%b ird=%h drd=%h, required %b%b %h %h", c,
                         I_RVALID, D_RVALID, I_RDATA, D_RDATA, e_iv, e_dv, m_ird, m_drd);
            end
            if (!idle && !own_d && I_KILL) killed = 1'b1;
            if (e_en) begin
                free_at = c + LAT + 1;
                done_at = c + LAT + 1;
                own_d = e_dg;
                killed = e_ig && I_KILL;
                exp_data = e_we ? 32'h0 : model_mem[e_addr[5:2]];
                if (e_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (D_BE[b]) model_mem[e_addr[5:2]][8*b +: 8] = D_WDATA[8*b +: 8];
                    end
                end
            end
            if (!I_REQ || e_ig) starve = 0;
            else if (e_dg && starve < SMAX) starve++;
            i_hold = I_REQ && !e_ig;
            d_hold = D_REQ && !e_dg;
            nxt();
        end
        I_REQ = 1'b0; D_REQ = 1'b0; I_KILL = 1'b0;
        repeat (LAT + 1) nxt();
    endtask

    initial begin
        RSTN = 1'b0; I_REQ = 1'b0; I_ADDR = 32'h0; I_KILL = 1'b0;
        drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_single_fetch();
        test_store_load();
        test_byte_store();
        test_kill();
        test_contention();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-port synchronous memory between the instruction fetch (IF) stage and the data access (MEM) stage of the RV32I pipeline. It accepts one request per port, grants the memory to one port at a time, and tracks the fixed memory read latency. It returns read data, or a write completion, to the granted port. Data accesses win by default; an anti-starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- MEM_LAT, 2: cycles from memory enable to valid M_RDATA; legal range ≥1.
- STARVE_MAX, 4: consecutive data grants allowed while I_REQ is pending before fetch is forced; legal range ≥1.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RSTN  in  1  reset, synchronous and active-low.
- I_REQ  in  1  fetch request; held with I_ADDR until I_GNT.
- I_ADDR  in  32  fetch byte address (word-aligned).
- I_KILL  in  1  discard the outstanding fetch response (branch flush).
- I_GNT  out  1  one-cycle pulse: fetch request accepted.
- I_RVALID  out  1  one-cycle pulse: I_RDATA valid.
- I_RDATA  out  32  fetched instruction.
- D_REQ  in  1  data request; held with D_WE, D_BE, D_ADDR and D_WDATA until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_BE  in  4  byte enables for stores.
- D_ADDR  in  32  data byte address.
- D_WDATA  in  32  store data.
- D_GNT  out  1  one-cycle pulse: data request accepted.
- D_RVALID  out  1  one-cycle pulse: load data valid, or store complete.
- D_RDATA  out  32  load data; 0 for stores.
- M_EN, M_WE  out  1  memory enable and write strobe.
- M_BE  out  4  memory byte enables.
- M_ADDR, M_WDATA  out  32  memory address and write data.
- M_RDATA  in  32  memory read data, valid MEM_LAT cycles after the M_EN cycle.
- BUSY  out  1  high while a transaction is outstanding.

## Operation
- FSM states: IDLE and WAIT. At most one transaction is outstanding.
- In IDLE with any request pending, choose a winner:
  - D wins if D_REQ is high, unless I_REQ is high and starve_cnt == STARVE_MAX.
  - Otherwise I wins if I_REQ is high.
- Same cycle as the choice, combinationally:
  - Pulse the winner's GNT.
  - Drive M_EN=1, M_WE=D_WE&(D winner), and M_ADDR/M_BE/M_WDATA from the winner.
  - A fetch drives M_BE=4'hF and M_WDATA=0.
- Then go to WAIT. Latch the owner (I/D), the kind (read/write) and wait_cnt=MEM_LAT.
- All M_* outputs are 0 whenever M_EN=0.
- WAIT:
  - Decrement wait_cnt each cycle.
  - On the cycle wait_cnt reaches 0, register M_RDATA into the owner's RDATA (0 for stores) and return to IDLE.
  - The owner's RVALID is asserted in the following cycle, which is the first IDLE cycle.
- starve_cnt (saturating, width clog2(STARVE_MAX+1)):
  - Increment on each D grant while I_REQ is high.
  - Clear on an I grant, and in any cycle with I_REQ low.
- I_KILL:
  - Sampled while a fetch is outstanding, including the grant cycle.
  - Sets a kill flag; the matching I_RVALID is suppressed and I_RDATA is left unchanged.
  - I_KILL has no effect on data transactions or in IDLE with no outstanding fetch.
- Requests arriving during WAIT wait; GNT is never asserted outside IDLE.

## Timing
- Grant at cycle t produces RVALID at t+MEM_LAT+1.
- A new grant may occur in the same cycle as RVALID (IDLE). Peak throughput is one access per MEM_LAT+1 cycles.
- BUSY is high from cycle t+1 through t+MEM_LAT.
- GNT and M_EN are combinational from state and requests; RVALID and RDATA are registered.
- Reset (RSTN low at a posedge):
  - State goes to IDLE; wait_cnt, starve_cnt and the kill flag clear.
  - All outputs are 0 the next cycle: GNT, RVALID, RDATA, M_*, BUSY.
- Reset during WAIT aborts the transaction; no RVALID is ever produced for it.
- Simultaneous I_REQ and D_REQ with starve_cnt < STARVE_MAX: D wins and I_REQ keeps waiting.

## Test plan
- Single fetch, MEM_LAT=2: I_REQ at cycle 0 with I_ADDR=0x100 and memory word 0x00500093.
  - Required: I_GNT and M_EN at cycle 0; I_RVALID at cycle 3 with I_RDATA=0x00500093; BUSY high in cycles 1–2.
- Store then load: D store of 0xDEADBEEF to 0x200 with D_BE=4'hF, then a load from 0x200.
  - Required: D_RVALID at cycle 3 with D_RDATA=0; second grant at cycle 3; D_RVALID at cycle 6 with 0xDEADBEEF.
- Contention: I_REQ and D_REQ held continuously, STARVE_MAX=4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I…, with grants spaced 3 cycles apart.
- Kill: fetch granted at cycle 0, I_KILL pulsed at cycle 1.
  - Required: no I_RVALID at cycle 3, I_RDATA unchanged; a D grant at cycle 3 completes normally.
- Reset mid-operation: D load granted at cycle 0, RSTN low at cycle 1.
  - Required: all outputs 0 from cycle 2; no D_RVALID afterwards; the first grant after release comes in the first cycle with RSTN high and a request.
- Byte store: D_BE=4'b0010 with D_WDATA=0x0000AB00 to 0x300.
  - Required: M_BE=4'b0010 and M_WE=1 in the grant cycle; a subsequent load returns byte 1 = 0xAB.
